tag_decoder_table: RTL and testbench
====================================

Name: tag_decoder_table

Overview:
- Registered binary-to-one-hot decoder with a busy-tag table. It is the counterpart of the priority encoder that picks free tags.
- Accepts binary tag indices on a set port (allocate) and a clear port (release). Each index is decoded to a one-hot mask and the SIZE-bit busy vector is updated.
- Sits beside the free-tag encoder in the rename/ROB tag allocation path. The encoder reads o_busy to choose the next free tag.

Parameters:
- SIZE, 32, number of tags (bits in busy vector and one-hot output)
- WIDTH, 5, binary tag width; WIDTH = ceil(log2(SIZE))

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous clear of whole table
- i_set_en  input  1  allocate request
- i_set_tag  input  WIDTH  tag to mark busy
- i_clr_en  input  1  release request
- i_clr_tag  input  WIDTH  tag to mark free
- o_dec  output  SIZE  registered one-hot decode of last accepted i_set_tag
- o_busy  output  SIZE  busy vector, bit n = tag n allocated
- o_count  output  WIDTH+1  number of busy tags
- o_full  output  1  o_count == SIZE
- o_empty  output  1  o_count == 0
- o_err  output  1  sticky protocol error flag

Behaviour:
- Reset (i_rst_n low, asynchronous, any time, including mid-update):
  - o_dec=0, o_busy=0, o_count=0, o_err=0.
  - o_full=0, o_empty=1.
- All updates happen on the rising i_clk edge. Results are visible the cycle after the request (1-cycle latency). No combinational path from inputs to outputs.
- o_full and o_empty decode combinationally from the o_count register.
- Tag validity: a tag is in range when tag < SIZE. An out-of-range tag with its enable high:
  - has no effect on o_busy or o_count;
  - sets o_err;
  - an out-of-range set drives o_dec=0.
- Set port, i_set_en=1 with in-range tag T:
  - o_dec <= one-hot(T);
  - busy[T] <= 1.
  - If busy[T] was already 1 and it is not also being cleared this cycle, that is a duplicate allocate: o_err <= 1 and o_count is unchanged.
- With i_set_en=0: o_dec <= 0. o_dec is a single-cycle pulse per allocation.
- Clear port, i_clr_en=1 with in-range tag C:
  - busy[C] <= 0, unless overridden by a set to the same tag.
  - If busy[C] was 0, that is a double release: o_err <= 1.
- Simultaneous set and clear, different tags: both apply. o_count changes by the net of the effective transitions (+1 -1 = 0 when both are effective).
- Simultaneous set and clear, same tag: clear is applied first, then set, so the bit ends at 1.
  - Bit was 1: no error, count unchanged.
  - Bit was 0: o_err <= 1 (release of a free tag), bit becomes 1, count +1.
- o_count is maintained incrementally:
  - +1 for each effective 0->1 bit transition, -1 for each effective 1->0 transition.
  - It never wraps; it always equals popcount(o_busy).
- Full condition: a set while o_full=1 is necessarily a duplicate; it is handled as a duplicate allocate (o_err).
- Flush:
  - Highest priority; set and clear in the same cycle are ignored.
  - o_busy=0, o_count=0, o_dec=0, o_err=0.
- o_err is sticky; only reset or flush clears it.
- There is no state machine beyond the registers. Next-state logic is pure combinational over the current registers and the inputs.

Decomposition:
- Shared package holds: TAG_SIZE=32, TAG_WIDTH=5, and the macro/function for the out-of-range compare.
- One natural sub-module: decoder (combinational binary-to-one-hot, parameters SIZE/WIDTH, ports i_en, i_d[WIDTH], o_q[SIZE]; o_q=0 when i_en=0 or i_d>=SIZE).
- Instantiate decoder twice: once for the set path, once for the clear path. The top level holds the registers, count logic and error logic.

Test Plan:
- Reset low, then release, no requests -> o_busy=0, o_dec=0, o_count=0, o_empty=1, o_full=0, o_err=0.
- Set tag 1, then tag 3, then tag 2 on consecutive cycles:
  - o_dec = 0x2, 0x8, 0x4 on the following cycles, then 0 once set is idle.
  - o_busy=0x0000000E, o_count=3.
- With busy=0x0E, same cycle set tag 5 and clear tag 1 -> o_busy=0x0000002C, o_count=3, o_err=0. Next cycle clear tag 1 again -> o_err=1, o_busy unchanged.
- Set tags 0..31 on 32 consecutive cycles:
  - o_full=1, o_count=32, o_busy=0xFFFFFFFF.
  - A further set of tag 7 -> o_err=1, o_count stays 32.
  - Then flush -> o_busy=0, o_count=0, o_err=0, o_empty=1.
- With busy=0x0E, same cycle set and clear tag 3 -> o_busy=0x0E, o_count=3, o_err=0. Then same-cycle set and clear tag 9 -> o_busy=0x20E, o_count=4, o_err=1.
- Assert i_rst_n low asynchronously between clock edges while o_busy=0x0F and i_set_en=1 -> all outputs return to reset values immediately, before the next edge. After reset deasserts, the first set of tag 4 gives o_busy=0x10, o_count=1.

Source files
------------

// File: rtl/tag_decoder_table_pkg.sv
// Shared definitions for the busy-tag table.
// Holds the default table geometry and the tag range compare used by the
// table's error logic.
package tag_decoder_table_pkg;

  localparam int TAG_SIZE  = 32;
  localparam int TAG_WIDTH = 5;

  // True when a tag index falls outside a table of 'size' entries.
  function automatic logic tag_out_of_range(input int unsigned tag,
                                            input int unsigned size);
    return (tag >= size);
  endfunction

endpackage

// File: rtl/tag_decoder_table_decoder.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   i_en  - decode enable; output is all zero when low
//   i_d   - binary index (WIDTH bits)
//   o_q   - one-hot result (SIZE bits); all zero when i_d >= SIZE
module tag_decoder_table_decoder #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 5
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [SIZE-1:0]  o_q
);

  // Compare the index against every position; an index at or beyond SIZE
  // matches no position, so it naturally decodes to zero.
  always_comb begin
    o_q = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (i_en && (i_d == WIDTH'(i))) begin
        o_q[i] = 1'b1;
      end else begin
        o_q[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tag_decoder_table.sv
// Busy-tag table with registered one-hot decode of the allocated tag.
// Sits beside the free-tag priority encoder, which reads o_busy.
// Ports:
//   i_clk, i_rst_n        - clock (rising edge), async active-low reset
//   i_flush               - synchronous clear of the whole table (top priority)
//   i_set_en / i_set_tag  - allocate request: mark tag busy
//   i_clr_en / i_clr_tag  - release request: mark tag free
//   o_dec                 - one-cycle one-hot pulse of the accepted set tag
//   o_busy                - busy vector, bit n = tag n allocated
//   o_count               - number of busy tags
//   o_full, o_empty       - decoded from the count register
//   o_err                 - sticky protocol error (duplicate allocate,
//                           double release, out-of-range tag)
module tag_decoder_table
  import tag_decoder_table_pkg::*;
#(
  parameter int SIZE  = TAG_SIZE,
  parameter int WIDTH = TAG_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_set_en,
  input  logic [WIDTH-1:0] i_set_tag,
  input  logic             i_clr_en,
  input  logic [WIDTH-1:0] i_clr_tag,
  output logic [SIZE-1:0]  o_dec,
  output logic [SIZE-1:0]  o_busy,
  output logic [WIDTH:0]   o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  logic [SIZE-1:0] busy_r;
  logic [SIZE-1:0] dec_r;
  logic [WIDTH:0]  count_r;
  logic            err_r;

  logic [SIZE-1:0] set_hot_s;
  logic [SIZE-1:0] clr_hot_s;
  logic [SIZE-1:0] busy_next_s;
  logic [SIZE-1:0] dec_next_s;
  logic [WIDTH:0]  count_next_s;
  logic            err_next_s;
  logic            set_oor_s;
  logic            clr_oor_s;
  logic            inc_s;
  logic            dec_cnt_s;
  logic            dup_set_s;
  logic            dbl_clr_s;

  tag_decoder_table_decoder #(.SIZE(SIZE), .WIDTH(WIDTH)) u_set_dec (
    .i_en (i_set_en),
    .i_d  (i_set_tag),
    .o_q  (set_hot_s)
  );

  tag_decoder_table_decoder #(.SIZE(SIZE), .WIDTH(WIDTH)) u_clr_dec (
    .i_en (i_clr_en),
    .i_d  (i_clr_tag),
    .o_q  (clr_hot_s)
  );

  // Next-state for busy vector, count, decode pulse and error flag.
  always_comb begin
    set_oor_s = i_set_en && tag_out_of_range(32'(i_set_tag), SIZE);
    clr_oor_s = i_clr_en && tag_out_of_range(32'(i_clr_tag), SIZE);

    // Clear applies first, then set, so a same-tag pair leaves the bit at 1.
    busy_next_s = (busy_r & ~clr_hot_s) | set_hot_s;

    // Duplicate allocate only if the bit stays busy without a same-cycle clear.
    dup_set_s = |(set_hot_s & busy_r & ~clr_hot_s);
    // Releasing a free tag is an error even when a set to it follows.
    dbl_clr_s = |(clr_hot_s & ~busy_r);

    // At most one 0->1 (set port) and one 1->0 (clear port) per cycle.
    inc_s     = |(set_hot_s & ~busy_r);
    dec_cnt_s = |(clr_hot_s & busy_r & ~set_hot_s);

    if (i_flush) begin
      busy_next_s  = '0;
      dec_next_s   = '0;
      count_next_s = '0;
      err_next_s   = 1'b0;
    end else begin
      dec_next_s   = set_hot_s;
      count_next_s = count_r + (WIDTH+1)'(inc_s) - (WIDTH+1)'(dec_cnt_s);
      err_next_s   = err_r | set_oor_s | clr_oor_s | dup_set_s | dbl_clr_s;
    end
  end

  // Table state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r  <= '0;
      dec_r   <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      busy_r  <= busy_next_s;
      dec_r   <= dec_next_s;
      count_r <= count_next_s;
      err_r   <= err_next_s;
    end
  end

  assign o_busy  = busy_r;
  assign o_dec   = dec_r;
  assign o_count = count_r;
  assign o_err   = err_r;
  assign o_full  = (count_r == (WIDTH+1)'(SIZE));
  assign o_empty = (count_r == '0);

endmodule

// File: tb/tb_tag_decoder_table.sv
// Self-checking bench for tag_decoder_table. A behavioural model computes the
// expected outputs when each request is driven and pushes them to a queue;
// they are popped and compared one clock later.
module tb_tag_decoder_table;

  localparam int SIZE  = 32;
  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             set_en;
  logic [WIDTH-1:0] set_tag;
  logic             clr_en;
  logic [WIDTH-1:0] clr_tag;
  logic [SIZE-1:0]  dec;
  logic [SIZE-1:0]  busy;
  logic [WIDTH:0]   count;
  logic             full;
  logic             empty;
  logic             err;

  typedef struct packed {
    logic [SIZE-1:0] dec;
    logic [SIZE-1:0] busy;
    logic [WIDTH:0]  count;
    logic            full;
    logic            empty;
    logic            err;
  } exp_t;

  exp_t exp_q[$];

  logic [SIZE-1:0] m_busy;
  logic            m_err;
  int              tests_run;
  int              tests_failed;

  tag_decoder_table dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_set_en  (set_en),
    .i_set_tag (set_tag),
    .i_clr_en  (clr_en),
    .i_clr_tag (clr_tag),
    .o_dec     (dec),
    .o_busy    (busy),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int popcount(input logic [SIZE-1:0] v);
    int n = 0;
    for (int i = 0; i < SIZE; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic exp_t pack_exp(input logic [SIZE-1:0] d);
    exp_t e;
    int   n = popcount(m_busy);
    e.dec   = d;
    e.busy  = m_busy;
    e.count = (WIDTH+1)'(n);
    e.full  = (n == SIZE);
    e.empty = (n == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic compare_all(input exp_t e);
    check("dec",   64'(dec),   64'(e.dec));
    check("busy",  64'(busy),  64'(e.busy));
    check("count", 64'(count), 64'(e.count));
    check("full",  64'(full),  64'(e.full));
    check("empty", 64'(empty), 64'(e.empty));
    check("err",   64'(err),   64'(e.err));
  endtask

  // Drive one request, model it, push the expectation, then pop and compare
  // one cycle later.
  task automatic cycle(input logic f, input logic se, input int st,
                       input logic ce, input int ct);
    logic [SIZE-1:0] nb;
    logic [SIZE-1:0] nd;
    exp_t            e;
    flush   = f;
    set_en  = se;
    set_tag = WIDTH'(st);
    clr_en  = ce;
    clr_tag = WIDTH'(ct);
    nb = m_busy;
    nd = '0;
    if (f) begin
      nb    = '0;
      m_err = 1'b0;
    end else begin
      if (ce) begin
        if (ct >= SIZE) m_err = 1'b1;
        else begin
          if (!m_busy[ct]) m_err = 1'b1;
          nb[ct] = 1'b0;
        end
      end
      if (se) begin
        if (st >= SIZE) m_err = 1'b1;
        else begin
          if (m_busy[st] && !(ce && ct == st)) m_err = 1'b1;
          nb[st] = 1'b1;
          nd[st] = 1'b1;
        end
      end
    end
    m_busy = nb;
    exp_q.push_back(pack_exp(nd));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      compare_all(e);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_busy  = '0;
    m_err   = 1'b0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    set_en  = 1'b0;
    set_tag = '0;
    clr_en  = 1'b0;
    clr_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    rst_n = 1'b1;
    idle();

    // Allocate 1, 3, 2 then go idle; decode pulses follow by one cycle.
    cycle(1'b0, 1'b1, 1, 1'b0, 0);
    check("dec_t1", 64'(dec), 64'h2);
    cycle(1'b0, 1'b1, 3, 1'b0, 0);
    check("dec_t3", 64'(dec), 64'h8);
    cycle(1'b0, 1'b1, 2, 1'b0, 0);
    check("dec_t2", 64'(dec), 64'h4);
    idle();
    check("dec_idle",  64'(dec),   64'h0);
    check("busy_0e",   64'(busy),  64'h0000000E);
    check("count_3",   64'(count), 64'd3);

    // Set 5 and clear 1 together, then release 1 again.
    cycle(1'b0, 1'b1, 5, 1'b1, 1);
    check("busy_2c",   64'(busy),  64'h0000002C);
    check("count_sc",  64'(count), 64'd3);
    check("err_sc",    64'(err),   64'd0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1);
    check("err_dblclr", 64'(err),  64'd1);
    check("busy_same",  64'(busy), 64'h0000002C);

    // Flush, rebuild 0x0E, then same-tag set+clear cases.
    cycle(1'b1, 1'b1, 6, 1'b1, 2);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_err",  64'(err),  64'd0);
    cycle(1'b0, 1'b1, 1, 1'b0, 0);
    cycle(1'b0, 1'b1, 2, 1'b0, 0);
    cycle(1'b0, 1'b1, 3, 1'b0, 0);
    cycle(1'b0, 1'b1, 3, 1'b1, 3);
    check("same3_busy",  64'(busy),  64'h0E);
    check("same3_count", 64'(count), 64'd3);
    check("same3_err",   64'(err),   64'd0);
    cycle(1'b0, 1'b1, 9, 1'b1, 9);
    check("same9_busy",  64'(busy),  64'h20E);
    check("same9_count", 64'(count), 64'd4);
    check("same9_err",   64'(err),   64'd1);

    // Fill the table completely.
    cycle(1'b1, 1'b0, 0, 1'b0, 0);
    for (int t = 0; t < SIZE; t++) cycle(1'b0, 1'b1, t, 1'b0, 0);
    check("full_flag",  64'(full),  64'd1);
    check("full_count", 64'(count), 64'd32);
    check("full_busy",  64'(busy),  64'hFFFFFFFF);
    check("full_err0",  64'(err),   64'd0);
    cycle(1'b0, 1'b1, 7, 1'b0, 0);
    check("full_dup_err",   64'(err),   64'd1);
    check("full_dup_count", 64'(count), 64'd32);
    cycle(1'b1, 1'b0, 0, 1'b0, 0);
    check("fl_busy",  64'(busy),  64'h0);
    check("fl_count", 64'(count), 64'd0);
    check("fl_err",   64'(err),   64'd0);
    check("fl_empty", 64'(empty), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, SIZE - 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, SIZE - 1)));
    end

    // Asynchronous reset between edges with busy = 0x0F and a set pending.
    cycle(1'b1, 1'b0, 0, 1'b0, 0);
    for (int t = 0; t < 4; t++) cycle(1'b0, 1'b1, t, 1'b0, 0);
    check("pre_rst_busy", 64'(busy), 64'h0F);
    set_en  = 1'b1;
    set_tag = WIDTH'(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  64'(busy),  64'h0);
    check("arst_dec",   64'(dec),   64'h0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_err",   64'(err),   64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_full",  64'(full),  64'd0);
    m_busy = '0;
    m_err  = 1'b0;
    set_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 4, 1'b0, 0);
    check("post_rst_busy",  64'(busy),  64'h10);
    check("post_rst_count", 64'(count), 64'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
